mips_alu_decoder: RTL and testbench

- Second-level ALU control decoder of the single-cycle/pipelined MIPS datapath.
- Maps the 2-bit aluop from the main control decoder plus the 6-bit R-type funct field to the 4-bit ALU control code.
- Output is registered: one clock of latency, with a valid strobe and an illegal-encoding flag for the hazard/exception logic.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_alu_decoder_funct_lut.sv | 23 ++
 rtl/mips_alu_decoder.sv | 45 ++++
 tb/tb_mips_alu_decoder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU control, aluop and funct encodings for the MIPS control path
package mips_pkg;
  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;
  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_ADDU = 6'd33;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SUBU = 6'd35;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SLTU = 6'd43;
endpackage

// File: rtl/mips_alu_decoder_funct_lut.sv
// alu_funct_lut: combinational R-type funct to ALU control code lookup
module alu_funct_lut
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] code,
  output logic       illegal
);
  always_comb begin
    code    = ALU_ILLEGAL;
    illegal = 1'b0;
    case (funct)
      FN_ADD, FN_ADDU: code = ALU_ADD;
      FN_SUB, FN_SUBU: code = ALU_SUB;
      FN_AND:          code = ALU_AND;
      FN_OR:           code = ALU_OR;
      FN_XOR:          code = ALU_XOR;
      FN_NOR:          code = ALU_NOR;
      FN_SLT, FN_SLTU: code = ALU_SLT;
      default:         illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: registered aluop/funct to ALU control decode with valid and illegal flags
module mips_alu_decoder
  import mips_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic [CTRL_W-1:0]  alu_control,
  output logic               out_valid,
  output logic               illegal
);
  logic [3:0] lut_code;
  logic       lut_illegal;
  logic [3:0] code;
  logic       ill;
  alu_funct_lut u_lut (
    .funct  (funct[5:0]),
    .code   (lut_code),
    .illegal(lut_illegal)
  );
  always_comb begin
    code = aluop == ALUOP_MEM   ? ALU_ADD :
           aluop == ALUOP_BR    ? ALU_SUB :
           aluop == ALUOP_RTYPE ? lut_code : ALU_ILLEGAL;
    ill  = aluop == ALUOP_RTYPE ? lut_illegal : aluop[1] & aluop[0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control <= CTRL_W'(ALU_ADD);
      out_valid   <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_control <= CTRL_W'(code);
        illegal     <= ill;
      end
    end
  end
endmodule

// File: tb/tb_mips_alu_decoder.sv
// tb_mips_alu_decoder: directed self-checking bench for mips_alu_decoder
module tb_mips_alu_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] aluop = 2'b00;
  logic [5:0] funct = 6'd0;
  logic [3:0] alu_control;
  logic       out_valid;
  logic       illegal;
  int checks = 0;
  int failures = 0;

  mips_alu_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .aluop      (aluop),
    .funct      (funct),
    .alu_control(alu_control),
    .out_valid  (out_valid),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    aluop = 2'b11;
    repeat (3) @(negedge clk);
    checks++; if (alu_control !== 4'b0010) begin failures++; $display("FAIL reset_ctrl got=%b exp=0010", alu_control); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mem_branch();
    in_valid = 1'b1; aluop = 2'b00; funct = 6'd36;
    @(negedge clk);
    checks++; if (alu_control !== 4'b0010) begin failures++; $display("FAIL mem_ctrl got=%b exp=0010", alu_control); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mem_valid got=%b exp=1", out_valid); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL mem_illegal got=%b exp=0", illegal); end
    aluop = 2'b01;
    @(negedge clk);
    checks++; if (alu_control !== 4'b0110) begin failures++; $display("FAIL br_ctrl got=%b exp=0110", alu_control); end
    aluop = 2'b10;
    @(negedge clk);
    checks++; if (alu_control !== 4'b0000) begin failures++; $display("FAIL and_ctrl got=%b exp=0000", alu_control); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fn [8] = '{6'd32, 6'd34, 6'd37, 6'd38, 6'd39, 6'd42, 6'd33, 6'd43};
    logic [3:0] ex [8] = '{4'b0010, 4'b0110, 4'b0001, 4'b0011, 4'b1100, 4'b0111, 4'b0010, 4'b0111};
    in_valid = 1'b1; aluop = 2'b10;
    for (int i = 0; i < 8; i++) begin
      funct = fn[i];
      @(negedge clk);
      checks++; if (alu_control !== ex[i] || illegal !== 1'b0) begin failures++; $display("FAIL sweep_funct%0d got=%b/%b exp=%b/0", fn[i], alu_control, illegal, ex[i]); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sweep_valid%0d got=%b exp=1", fn[i], out_valid); end
    end
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; aluop = 2'b10; funct = 6'd0;
    @(negedge clk);
    checks++; if (alu_control !== 4'b1111) begin failures++; $display("FAIL fn0_ctrl got=%b exp=1111", alu_control); end
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL fn0_illegal got=%b exp=1", illegal); end
    aluop = 2'b11; funct = 6'd32;
    @(negedge clk);
    checks++; if (alu_control !== 4'b1111) begin failures++; $display("FAIL op11_ctrl got=%b exp=1111", alu_control); end
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL op11_illegal got=%b exp=1", illegal); end
    aluop = 2'b10; funct = 6'd40;
    @(negedge clk);
    checks++; if (alu_control !== 4'b1111 || illegal !== 1'b1) begin failures++; $display("FAIL fn40 got=%b/%b exp=1111/1", alu_control, illegal); end
    aluop = 2'b00;
    @(negedge clk);
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_clear got=%b exp=0", illegal); end
  endtask

  task automatic test_hold();
    in_valid = 1'b1; aluop = 2'b01; funct = 6'd0;
    @(negedge clk);
    in_valid = 1'b0; aluop = 2'b11; funct = 6'd36;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_valid got=%b exp=0", out_valid); end
    checks++; if (alu_control !== 4'b0110 || illegal !== 1'b0) begin failures++; $display("FAIL hold_ctrl got=%b/%b exp=0110/0", alu_control, illegal); end
    @(negedge clk);
    checks++; if (alu_control !== 4'b0110) begin failures++; $display("FAIL hold2_ctrl got=%b exp=0110", alu_control); end
  endtask

  task automatic test_midstream_reset();
    in_valid = 1'b1; aluop = 2'b11;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (alu_control !== 4'b0010) begin failures++; $display("FAIL async_ctrl got=%b exp=0010", alu_control); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", out_valid); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL async_illegal got=%b exp=0", illegal); end
    @(negedge clk);
    rst_n = 1'b1; aluop = 2'b10; funct = 6'd39;
    @(negedge clk);
    checks++; if (alu_control !== 4'b1100 || out_valid !== 1'b1) begin failures++; $display("FAIL post_reset got=%b/%b exp=1100/1", alu_control, out_valid); end
    in_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mem_branch();
    test_back_to_back();
    test_illegal();
    test_hold();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
